// File: rtl/game_tick_ctrl.sv
// game_tick_ctrl: sequencer for one snake game step.
//
// Paces moves with a tick counter, requests the next-map computation, waits
// for the collision checker flags to settle, then commits the step, requests
// a point respawn when a snake has eaten, asks the renderer for a frame, and
// latches the match result when the game ends.
//
// Optional feature macro: GAME_PAUSE_EN (adds the pause input; while high in
// WAIT_TICK the tick counter holds its value).
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   pause        (GAME_PAUSE_EN only) hold the move timer
//   mode         top-level mode; the controller runs only in GAME
//   calc_req     level, requests map_nxt computation until calc_done
//   calc_done    one-cycle pulse, map_nxt stable
//   eaten1/2     collision checker: snake 1/2 ate a point
//   won/lost/draw collision checker: match outcome flags
//   commit       one-cycle pulse, map <= map_nxt
//   grow1/2      one-cycle pulses coincident with commit
//   spawn_req    level, place a new POINT until spawn_done
//   spawn_done   one-cycle pulse
//   refresh_req  level, until the renderer reports refreshed
//   refreshed    renderer finished a frame
//   game_over    level, match finished
//   result       00 none, 01 won, 10 lost, 11 draw; valid while game_over
//   busy         high in every state except IDLE, WAIT_TICK and OVER

package game_tick_ctrl_pkg;
  typedef enum logic [1:0] {
    MENU  = 2'd0,
    GAME  = 2'd1,
    SETUP = 2'd2,
    SCORE = 2'd3
  } game_mode;
endpackage

module game_tick_ctrl
  import game_tick_ctrl_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 25_000_000,
  parameter int unsigned CHECK_LAT   = 2,
  parameter int unsigned TIMER_W     = 32
) (
  input  logic       clk,
  input  logic       rst,
`ifdef GAME_PAUSE_EN
  input  logic       pause,
`endif
  input  game_mode   mode,
  output logic       calc_req,
  input  logic       calc_done,
  input  logic       eaten1,
  input  logic       eaten2,
  input  logic       won,
  input  logic       lost,
  input  logic       draw,
  output logic       commit,
  output logic       grow1,
  output logic       grow2,
  output logic       spawn_req,
  input  logic       spawn_done,
  output logic       refresh_req,
  input  logic       refreshed,
  output logic       game_over,
  output logic [1:0] result,
  output logic       busy
);

  localparam int unsigned CHK_W = $clog2(CHECK_LAT + 1);
  localparam logic [TIMER_W-1:0] TICK_LAST = TIMER_W'(TICK_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_TICK,
    ST_CALC,
    ST_CHECK,
    ST_COMMIT,
    ST_SPAWN,
    ST_REFRESH,
    ST_OVER
  } state_t;

  state_t               state_q;
  state_t               state_nxt;
  logic [TIMER_W-1:0]   tick_q;
  logic [TIMER_W-1:0]   tick_nxt;
  logic [CHK_W-1:0]     chk_q;
  logic [CHK_W-1:0]     chk_nxt;
  logic [1:0]           eat_q;
  logic [1:0]           eat_nxt;
  logic [1:0]           res_nxt;

  logic                 calc_req_d;
  logic                 commit_d;
  logic [1:0]           grow_d;
  logic                 spawn_req_d;
  logic                 refresh_req_d;
  logic                 game_over_d;
  logic                 busy_d;

  // Timer hold request; tied off when the pause feature is not built.
  logic                 tick_hold;
`ifdef GAME_PAUSE_EN
  assign tick_hold = pause;
`else
  assign tick_hold = 1'b0;
`endif

  // State and datapath registers, plus the registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      tick_q      <= '0;
      chk_q       <= '0;
      eat_q       <= '0;
      calc_req    <= 1'b0;
      commit      <= 1'b0;
      grow1       <= 1'b0;
      grow2       <= 1'b0;
      spawn_req   <= 1'b0;
      refresh_req <= 1'b0;
      game_over   <= 1'b0;
      result      <= 2'b00;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      tick_q      <= tick_nxt;
      chk_q       <= chk_nxt;
      eat_q       <= eat_nxt;
      calc_req    <= calc_req_d;
      commit      <= commit_d;
      grow1       <= grow_d[0];
      grow2       <= grow_d[1];
      spawn_req   <= spawn_req_d;
      refresh_req <= refresh_req_d;
      game_over   <= game_over_d;
      result      <= res_nxt;
      busy        <= busy_d;
    end
  end

  // Next-state and datapath update. The tick counter is zero outside
  // WAIT_TICK, so every entry into WAIT_TICK starts a full tick period.
  always_comb begin
    state_nxt = state_q;
    tick_nxt  = '0;
    chk_nxt   = chk_q;
    eat_nxt   = eat_q;
    res_nxt   = result;

    if (mode != GAME) begin
      // Leaving GAME aborts the step: nothing committed, requests drop.
      state_nxt = ST_IDLE;
      chk_nxt   = '0;
      eat_nxt   = '0;
      res_nxt   = 2'b00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_nxt = ST_WAIT_TICK;
        end

        ST_WAIT_TICK: begin
          if (tick_hold) begin
            tick_nxt = tick_q;
          end else if (tick_q == TICK_LAST) begin
            state_nxt = ST_CALC;
          end else begin
            tick_nxt = tick_q + TIMER_W'(1);
          end
        end

        ST_CALC: begin
          if (calc_done) begin
            state_nxt = ST_CHECK;
            chk_nxt   = CHK_W'(CHECK_LAT);
          end
        end

        // Flags are sampled on the edge where the count reaches zero, i.e.
        // CHECK_LAT cycles after calc_done.
        ST_CHECK: begin
          if (chk_q <= CHK_W'(1)) begin
            chk_nxt = '0;
            if (draw) begin
              res_nxt   = 2'b11;
              state_nxt = ST_OVER;
            end else if (lost) begin
              res_nxt   = 2'b10;
              state_nxt = ST_OVER;
            end else if (won) begin
              res_nxt   = 2'b01;
              state_nxt = ST_OVER;
            end else begin
              eat_nxt   = {eaten2, eaten1};
              state_nxt = ST_COMMIT;
            end
          end else begin
            chk_nxt = chk_q - CHK_W'(1);
          end
        end

        // One spawn request regardless of how many snakes ate.
        ST_COMMIT: begin
          state_nxt = (eat_q != 2'b00) ? ST_SPAWN : ST_REFRESH;
          eat_nxt   = '0;
        end

        ST_SPAWN: begin
          if (spawn_done) begin
            state_nxt = ST_REFRESH;
          end
        end

        ST_REFRESH: begin
          if (refreshed) begin
            state_nxt = ST_WAIT_TICK;
          end
        end

        ST_OVER: begin
          state_nxt = ST_OVER;
        end

        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Output decode from the next state so every output leaves a flop.
  always_comb begin
    calc_req_d    = (state_nxt == ST_CALC);
    commit_d      = (state_nxt == ST_COMMIT);
    grow_d        = commit_d ? eat_nxt : 2'b00;
    spawn_req_d   = (state_nxt == ST_SPAWN);
    refresh_req_d = (state_nxt == ST_REFRESH);
    game_over_d   = (state_nxt == ST_OVER);
    busy_d        = !((state_nxt == ST_IDLE) ||
                      (state_nxt == ST_WAIT_TICK) ||
                      (state_nxt == ST_OVER));
  end

endmodule
